// File: rtl/reg_file_arbiter_pkg.sv
// reg_file_arbiter_pkg -- shared definitions for the register file and its
// two-master access arbiter.
//   DATA_W_DEF / ADDR_W_DEF : default register data / address widths
//   state_t                 : access FSM state encoding
package reg_file_arbiter_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;
endpackage

// File: rtl/reg_file_arbiter_if.sv
// reg_file_arbiter_if -- bundles the two master request channels, their
// grant/done handshakes, the read result and the register-file port.
//   slave  modport : seen by the arbiter (requests in, grants/rf port out)
//   master modport : seen by the requesters + register file
interface reg_file_arbiter_if
    import reg_file_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();
    logic              req0, req1;
    logic              wr0, wr1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
    logic              done0, done1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, rf_rdata,
        output gnt0, gnt1, done0, done1, rdata, busy, rf_we, rf_addr, rf_wdata
    );

    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, rf_rdata,
        input  gnt0, gnt1, done0, done1, rdata, busy, rf_we, rf_addr, rf_wdata
    );
endinterface

// File: rtl/reg_file_arbiter_rr_arbiter2.sv
// rr_arbiter2 -- two-way combinational arbiter.
//   req0, req1 : requests
//   pointer    : tie-break owner (0 = master 0, 1 = master 1)
//   grant      : one-hot grant, bit i = master i (zero when no request)
module rr_arbiter2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       pointer,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        if (req0 && req1)
            grant = pointer ? 2'b10 : 2'b01;
        else if (req0)
            grant = 2'b01;
        else if (req1)
            grant = 2'b10;
    end
endmodule

// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter -- arbitrates two masters onto a single register-file
// port. Each transaction takes IDLE -> ACCESS -> RESP (one access per 3
// cycles); the request is latched in IDLE so masters may change their
// fields afterwards.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : reg_file_arbiter_if.slave (requests, gnt/done, rdata, busy,
//                register-file write/read port)
// Macro RF_ARB_ROUND_ROBIN_EN: rotating tie-break pointer; when undefined,
// master 0 always wins ties.
module reg_file_arbiter
    import reg_file_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    reg_file_arbiter_if.slave   bus
);
    state_t            state;
    logic              win1;      // latched winner, 1 = master 1
    logic              lat_wr;
    logic              ptr;
    logic [1:0]        grant;
    logic [1:0]        gnt_q, done_q;
    logic              busy_q, rf_we_q;
    logic [ADDR_W-1:0] rf_addr_q;
    logic [DATA_W-1:0] rf_wdata_q, rdata_q;

    rr_arbiter2 u_arb (
        .req0    (bus.req0),
        .req1    (bus.req1),
        .pointer (ptr),
        .grant   (grant)
    );

`ifdef RF_ARB_ROUND_ROBIN_EN
    // Hand priority to the loser as the transaction retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= 1'b0;
        else if (state == RESP)
            ptr <= ~win1;
    end
`else
    assign ptr = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            win1       <= 1'b0;
            lat_wr     <= 1'b0;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            busy_q     <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        // rf_addr/rf_wdata registers double as the latched
                        // transaction fields; they hold until the next win.
                        win1       <= grant[1];
                        lat_wr     <= grant[1] ? bus.wr1 : bus.wr0;
                        rf_we_q    <= grant[1] ? bus.wr1 : bus.wr0;
                        rf_addr_q  <= grant[1] ? bus.addr1 : bus.addr0;
                        rf_wdata_q <= grant[1] ? bus.wdata1 : bus.wdata0;
                        gnt_q      <= grant;
                        busy_q     <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!lat_wr)
                        rdata_q <= bus.rf_rdata;
                    rf_we_q <= 1'b0;
                    gnt_q   <= 2'b00;
                    done_q  <= win1 ? 2'b10 : 2'b01;
                    state   <= RESP;
                end
                RESP: begin
                    done_q <= 2'b00;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    gnt_q   <= 2'b00;
                    done_q  <= 2'b00;
                    rf_we_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0     = gnt_q[0];
    assign bus.gnt1     = gnt_q[1];
    assign bus.done0    = done_q[0];
    assign bus.done1    = done_q[1];
    assign bus.busy     = busy_q;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_addr  = rf_addr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.rdata    = rdata_q;
endmodule

// File: tb/tb_reg_file_arbiter.sv
// tb_reg_file_arbiter -- randomized + directed bench for reg_file_arbiter.
// A transaction-level model predicts each winner, its fields and the read
// result; expectations are queued and a negedge monitor checks them when
// the DUT shows gnt/done. Honors RF_ARB_ROUND_ROBIN_EN like the DUT.
module tb_reg_file_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reg_file_arbiter_if bus ();

    reg_file_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural register file sitting behind the arbiter.
    logic [31:0] rf_mem [8];
    assign bus.rf_rdata = rf_mem[bus.rf_addr];
    always @(posedge clk) if (bus.rf_we) rf_mem[bus.rf_addr] <= bus.rf_wdata;

    typedef struct {
        bit          who;
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        exp_q [$];
    int          tests = 0, fails = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    bit          mon_en = 1'b0;
    // Reference model state: memory contents, last read value, tie owner,
    // and how many more cycles the current transaction keeps the port.
    logic [31:0] m_mem [8];
    logic [31:0] m_rd = '0;
    bit          m_ptr = 1'b0;
    int          m_busy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model decides what the DUT will accept.
    task automatic step(input bit r0, input bit w0, input logic [2:0] a0, input logic [31:0] d0,
                        input bit r1, input bit w1, input logic [2:0] a1, input logic [31:0] d1);
        exp_t e;
        @(negedge clk);
        #1;
        bus.req0 = r0; bus.wr0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.wr1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        if (m_busy == 0) begin
            if (r0 || r1) begin
                e.who   = (r0 && r1) ? m_ptr : r1;
                e.wr    = e.who ? w1 : w0;
                e.addr  = e.who ? a1 : a0;
                e.wdata = e.who ? d1 : d0;
                e.cyc   = cyc;
                if (e.wr) begin
                    e.rdata = m_rd;
                    m_mem[e.addr] = e.wdata;
                end else begin
                    e.rdata = m_mem[e.addr];
                    m_rd = e.rdata;
                end
`ifdef RF_ARB_ROUND_ROBIN_EN
                m_ptr = !e.who;
`endif
                exp_q.push_back(e);
                m_busy = 2;
            end
        end else begin
            m_busy--;
        end
    endtask

    task automatic idle_step();
        step(0, 0, 3'd0, 32'd0, 0, 0, 3'd0, 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && mon_en) begin
            chk("busy", bus.busy, (m_busy != 0));
            chk("gnt_excl", bus.gnt0 & bus.gnt1, 0);
            chk("done_excl", bus.done0 & bus.done1, 0);
            if (bus.gnt0 || bus.gnt1) begin
                if (exp_q.size() == 0) begin
                    chk("gnt_spurious", {bus.gnt1, bus.gnt0}, 0);
                end else begin
                    e = exp_q[0];
                    chk("gnt_who", {bus.gnt1, bus.gnt0}, e.who ? 2'b10 : 2'b01);
                    chk("gnt_rf_we", bus.rf_we, e.wr);
                    chk("gnt_rf_addr", bus.rf_addr, e.addr);
                    chk("gnt_rf_wdata", bus.rf_wdata, e.wdata);
                    chk("gnt_latency", cyc, e.cyc + 1);
                end
            end else begin
                chk("rf_we_outside_access", bus.rf_we, 0);
            end
            if (bus.done0 || bus.done1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("done_spurious", {bus.done1, bus.done0}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_who", {bus.done1, bus.done0}, e.who ? 2'b10 : 2'b01);
                    chk("done_rdata", bus.rdata, e.rdata);
                    chk("done_rf_addr_held", bus.rf_addr, e.addr);
                    chk("done_latency", cyc, e.cyc + 2);
                end
            end
        end
    end

    initial begin
        logic [31:0] saved;
        int          d0;
        int          guard;
        for (int i = 0; i < 8; i++) begin
            rf_mem[i] = '0;
            m_mem[i]  = '0;
        end
        bus.req0 = 0; bus.wr0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.wr1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
        #3;
        chk("reset_ctrl", {bus.busy, bus.rf_we, bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 0);
        chk("reset_rdata", bus.rdata, 0);
        chk("reset_rf_addr", bus.rf_addr, 0);
        chk("reset_rf_wdata", bus.rf_wdata, 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;

        // Single write then read back from the other master.
        step(1, 1, 3'd5, 32'hDEADBEEF, 0, 0, 3'd0, 32'd0);
        idle_step(); idle_step();
        step(0, 0, 3'd0, 32'd0, 1, 0, 3'd5, 32'd0);
        idle_step(); idle_step(); idle_step();
        chk("readback_rdata", bus.rdata, 32'hDEADBEEF);

        // Field change after sampling: fields must come from the latched copy.
        step(1, 1, 3'd2, 32'h1234_5678, 0, 0, 3'd0, 32'd0);
        step(0, 1, 3'd7, 32'hFFFF_0000, 0, 0, 3'd0, 32'd0);
        idle_step(); idle_step();

        // Contention: both held for 12 cycles -> 4 completions.
        d0 = done_cnt;
        for (int i = 0; i < 12; i++)
            step(1, 0, 3'(i), 32'd0, 1, 1, 3'(i + 1), 32'(i * 7));
        chk("contention_done_count", done_cnt - d0, 4);
        idle_step(); idle_step(); idle_step();

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom);
        for (int i = 0; i < 4; i++) idle_step();

        // Reset in the middle of a write's ACCESS cycle.
        saved = m_mem[3];
        step(1, 1, 3'd3, 32'hA5A5_5A5A, 0, 0, 3'd0, 32'd0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        bus.req0 = 0; bus.req1 = 0;
        #1;
        chk("midreset_rf_we", bus.rf_we, 0);
        chk("midreset_ctrl", {bus.busy, bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 0);
        chk("midreset_rdata", bus.rdata, 0);
        exp_q.delete();
        m_busy = 0; m_ptr = 1'b0; m_rd = '0; m_mem[3] = saved;
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Idle: nothing may move for 10 cycles (monitor flags stray done).
        for (int i = 0; i < 10; i++) begin
            idle_step();
            chk("idle_quiet", {bus.busy, bus.rf_we, bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 0);
        end
        chk("midreset_no_write", rf_mem[3], saved);

        // Read back the untouched register after reset.
        step(0, 0, 3'd0, 32'd0, 1, 0, 3'd3, 32'd0);
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            idle_step();
            guard++;
        end
        chk("drain_timeout", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reg_file_arbiter.md
REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 3, register address width (8 registers).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0 / req1  input  1 each  access request from master 0 / master 1.
REQ-006 wr0 / wr1  input  1 each  1 = write, 0 = read.
REQ-007 addr0 / addr1  input  ADDR_W each  target register.
REQ-008 wdata0 / wdata1  input  DATA_W each  write data.
REQ-009 gnt0 / gnt1  output  1 each  high during the ACCESS cycle of that master's transaction.
REQ-010 done0 / done1  output  1 each  one-cycle completion pulse.
REQ-011 rdata  output  DATA_W  registered read result.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 rf_we  output  1  register-file write enable.
REQ-014 rf_addr  output  ADDR_W  register-file address, which feeds both the write decoder and the 8:1 read mux select.
REQ-015 rf_wdata  output  DATA_W  register-file write data.
REQ-016 rf_rdata  input  DATA_W  combinational read-mux output of the register file.

Function
REQ-017 The FSM SHALL have three states, IDLE -> ACCESS -> RESP -> IDLE, with one cycle each in ACCESS and RESP.
REQ-018 In IDLE with no req, the FSM SHALL stay in IDLE.
REQ-019 In IDLE with any req, the FSM SHALL select a winner and latch its wr, addr and wdata; the next state is ACCESS.
REQ-020 Arbitration when only one req is high: that master wins.
REQ-021 Arbitration when both reqs are high: the master indicated by the priority pointer wins.
REQ-022 In ACCESS, the block SHALL drive the latched addr and wdata on rf_addr and rf_wdata, and drive rf_we equal to the latched wr.
REQ-023 In ACCESS, gnt of the winner SHALL be 1.
REQ-024 In ACCESS on a read, rf_rdata SHALL be captured into rdata at the clock edge.
REQ-025 In ACCESS on a write, rdata SHALL hold its previous value.
REQ-026 In RESP, done of the winner SHALL be 1 for exactly one cycle.
REQ-027 On the RESP -> IDLE edge, the priority pointer SHALL move to the non-winner.
REQ-028 Latency: done SHALL assert 2 cycles after the IDLE cycle in which req is sampled.
REQ-029 Throughput: at most one access per 3 cycles.
REQ-030 Requests SHALL be sampled only in IDLE; req changes during ACCESS or RESP are ignored.
REQ-031 Transaction fields SHALL come only from the latched copy, so the requester may change addr/wdata after gnt.
REQ-032 A req still high in the IDLE cycle after done SHALL be treated as a new request.
REQ-033 Outside ACCESS: rf_we = 0 and gnt0 = gnt1 = 0; rf_addr and rf_wdata hold their latched values.
REQ-034 gnt0 and gnt1 SHALL never be high together, and done0 and done1 SHALL never be high together.
REQ-035 rdata SHALL hold its value until the next read completes.

Reset
REQ-036 Asserting reset SHALL immediately force state = IDLE and priority pointer = master 0.
REQ-037 Reset values: rf_we, gnt0, gnt1, done0, done1 and busy = 0; rdata, rf_addr and rf_wdata = 0.
REQ-038 Reset during ACCESS SHALL drop rf_we asynchronously; the write is not guaranteed and no done is issued.
REQ-039 Reset during RESP SHALL suppress the pending done pulse.

Configuration
REQ-040 With macro RF_ARB_ROUND_ROBIN_EN defined, arbitration SHALL use the rotating priority pointer as specified above.
REQ-041 Without RF_ARB_ROUND_ROBIN_EN, master 0 SHALL always win ties and the pointer logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-042 The state encodings (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2) and the DATA_W/ADDR_W defaults SHALL live in a shared package or include file used by the register file and this block.
REQ-043 Arbitration SHALL be one sub-module, rr_arbiter2 (inputs: req0, req1, pointer; output: one-hot grant), and the FSM SHALL stay in the top module.

Verification
REQ-044 Single write: reset, then req0 = 1, wr0 = 1, addr0 = 5, wdata0 = 32'hDEADBEEF -> gnt0 high one cycle later with rf_we = 1, rf_addr = 5; done0 two cycles after sampling.
REQ-045 Read back: req1 = 1, wr1 = 0, addr1 = 5 with rf_rdata = 32'hDEADBEEF -> done1 pulse and rdata = 32'hDEADBEEF.
REQ-046 Contention: req0 = req1 = 1 held continuously -> grants alternate 0, 1, 0, 1 (with the macro) or always 0 (without); one done per 3 cycles.
REQ-047 Field change: addr0 changed from 2 to 7 in the ACCESS cycle -> rf_addr stays 2 for the whole transaction.
REQ-048 Reset mid-ACCESS: reset asserted during the write cycle -> rf_we drops immediately, no done0, state IDLE, rdata = 0.
REQ-049 Idle check: no req for 10 cycles -> busy, rf_we and all gnt/done stay 0.
